sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Parametrised serial-in/parallel-out deserialiser. Successor to the fixed 4-bit SIPO shifter.
- Adds configurable width and bit order, a bit counter, and a valid/ready handshake on both sides so that back-pressure never loses a bit.
- Sits between single-bit serial sources (UART/SPI-style front ends, testbench bit streams) and word-wide datapath consumers.

Parameters:
- WIDTH, 8: parallel word width in bits; legal range 2..64.
- MSB_FIRST, 1: 1 = the first received bit lands in out_data[WIDTH-1]; 0 = the first received bit lands in out_data[0].

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear; discards the partial word and the held word.
- in_bit  in  1  serial data bit.
- in_valid  in  1  in_bit is valid this cycle.
- in_ready  out  1  deserialiser can accept a bit this cycle.
- out_data  out  WIDTH  assembled word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts out_data this cycle.
- bit_cnt  out  $clog2(WIDTH+1)  bits collected in the current partial word.
- out_perr  out  1  parity error flag for the held word; see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous): shift register = 0, bit_cnt = 0, out_data = 0, out_valid = 0, out_perr = 0. Release takes effect on the next clk edge.
- Bit accept: a bit is accepted when in_valid && in_ready at the clk rising edge.
- Shift direction:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], in_bit}.
  - MSB_FIRST=0: sreg <= {in_bit, sreg[WIDTH-1:1]}.
- Counter: bit_cnt increments by 1 per accepted bit, in the range 0..WIDTH-1.
- Word complete: when a bit is accepted with bit_cnt == WIDTH-1:
  - the completed word (including the new bit) loads into out_data;
  - out_valid <= 1;
  - bit_cnt <= 0.
  - Latency: out_valid rises on the edge that accepts the last bit and is visible in the following cycle.
- Output handshake:
  - out_valid && out_ready at an edge consumes the word; out_valid <= 0 unless a new word completes on the same edge.
  - out_data holds its value while out_valid=1 and out_ready=0.
- Back-pressure: in_ready = !(bit_cnt == WIDTH-1 && out_valid && !out_ready).
  - in_ready is combinational from registered state and out_ready; it has no path from in_valid.
  - Partial-word bits are always accepted. Only the completing bit stalls.
- Simultaneous consume and complete (out_ready=1 on the completing edge): the old word is consumed, the new word loads, out_valid stays 1, zero bubble.
- Continuous operation: with in_valid=1 and out_ready=1 held high, throughput is one word per WIDTH cycles and no bit is dropped.
- clr:
  - on the next edge: bit_cnt <= 0, sreg <= 0, out_valid <= 0, out_perr <= 0;
  - out_data is left unchanged;
  - clr has priority over a simultaneous bit accept or consume; that bit is dropped.
- Reset mid-word: all partial state is discarded; nothing is emitted on release.
- in_bit is ignored whenever in_valid=0. Unknown bits on in_bit are not filtered.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit.
  - bit_cnt counts 0..WIDTH. The completing bit is the parity bit; the stall rule uses bit_cnt == WIDTH.
  - On completion, out_perr <= (^data_bits) ^ parity_bit and is registered with out_data. It is 1 on mismatch.
  - The parity bit is not stored in out_data.
  - Throughput becomes one word per WIDTH+1 accepted bits.
- Undefined: the port is still present and out_perr is tied to 0; frame = WIDTH bits.

Test Plan:
- Reset: assert rst_n=0 mid-word with bit_cnt=5 -> next cycle all outputs 0, out_valid=0; after release, stream 0xA5 -> exactly one word 0xA5.
- Bit order: WIDTH=8, MSB_FIRST=1, stream 1,0,1,0,0,1,0,1 with out_ready=1 -> out_data=8'hA5, out_valid high one cycle. MSB_FIRST=0 with the same stream -> 8'hA5 bit-reversed = 8'hA5 (palindrome); repeat with 1,1,0,0,0,0,0,0 -> 8'h03.
- Back-pressure: out_ready=0, send 0x3C then 7 bits of 0xF0 -> in_ready=0 at bit_cnt=7 and out_data holds 0x3C; raise out_ready -> 0x3C consumed, last bit accepted, then out_data=0xF0.
- Zero-bubble: in_valid=1 and out_ready=1 continuous for 3 words 0x01,0x80,0xFF -> out_valid pulses every 8 cycles, data in order, in_ready never low.
- clr: clr at bit_cnt=4 with a simultaneous in_valid -> bit_cnt=0, out_valid=0; the next 8 bits form a clean word.
- SIPO_PARITY_EN: WIDTH=8, send 0x0F+parity 0 -> out_perr=0; send 0x0F+parity 1 -> out_perr=1, out_data=0x0F.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserialiser with valid/ready on both sides and configurable bit order.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per frame and report mismatches on out_perr.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         in_bit,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         out_perr
);

  localparam int CW = $clog2(WIDTH+1);
`ifdef SIPO_PARITY_EN
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
`endif

  logic [WIDTH-1:0] sreg_q, sreg_d, shifted, word;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             perr_q, perr_d, perr_calc;
  logic             accept, complete;

  assign in_ready = !(cnt_q == LAST && vld_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && (cnt_q == LAST);

  always_comb begin
    shifted = '0;
    if (MSB_FIRST) shifted = {sreg_q[WIDTH-2:0], in_bit};
    else           shifted = {in_bit, sreg_q[WIDTH-1:1]};
  end

  // With parity the completing bit is the parity bit, so the word is already in sreg.
  always_comb begin
`ifdef SIPO_PARITY_EN
    word      = sreg_q;
    perr_calc = (^sreg_q) ^ in_bit;
`else
    word      = shifted;
    perr_calc = 1'b0;
`endif
  end

  always_comb begin
    sreg_d = sreg_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    perr_d = perr_q;
    if (clr) begin
      sreg_d = '0;
      cnt_d  = '0;
      vld_d  = 1'b0;
      perr_d = 1'b0;
    end else begin
      if (vld_q && out_ready) vld_d = 1'b0;
      if (complete) begin
        sreg_d = word;
        data_d = word;
        cnt_d  = '0;
        vld_d  = 1'b1;
        perr_d = perr_calc;
      end else if (accept) begin
        sreg_d = shifted;
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      perr_q <= perr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = vld_q;
  assign bit_cnt   = cnt_q;
  assign out_perr  = perr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: MSB-first and LSB-first instances share one bit stream.
module tb_sipo_deserializer;
  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic gclk = 1'b0;
  logic rst_n, clr, in_bit, in_valid, out_ready;
  logic in_ready, out_valid, out_perr;
  logic [W-1:0] out_data;
  logic [3:0] bit_cnt;
  logic lsb_ready, lsb_valid, lsb_perr;
  logic [W-1:0] lsb_data;
  logic [3:0] lsb_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 gclk = ~gclk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(gclk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .bit_cnt(bit_cnt), .out_perr(out_perr));

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(gclk), .rst_n(rst_n), .clr(clr), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(lsb_ready), .out_data(lsb_data), .out_valid(lsb_valid),
    .out_ready(out_ready), .bit_cnt(lsb_cnt), .out_perr(lsb_perr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge gclk); #1;
  endtask

  function automatic logic fbit(input logic [W-1:0] w, input logic p, input int i);
    if (i < W) return w[W-1-i];
    return p;
  endfunction

  task automatic send_bit(input logic b);
    bit done;
    done = 1'b0;
    in_bit = b; in_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (in_ready) done = 1'b1;
      step;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic p);
    for (int i = 0; i < FRAME; i++) send_bit(fbit(w, p, i));
  endtask

  initial begin
    int stall_bad, pulse_bad;
    logic [W-1:0] zb_words [3];
    zb_words[0] = 8'h01; zb_words[1] = 8'h80; zb_words[2] = 8'hFF;
    rst_n = 1'b0; clr = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_cnt",   64'(bit_cnt),   64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data",  64'(out_data),  64'(0));
    chk("rst_perr",  64'(out_perr),  64'(0));
    chk("rst_lsb",   64'({lsb_cnt, lsb_valid, lsb_perr, lsb_data}), 64'(0));
    step; step; rst_n = 1'b1;

    send_word(8'hFF, 1'b0);
    chk("pre_data", 64'(out_data), 64'(8'hFF));
    step;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("mid_cnt5", 64'(bit_cnt), 64'(5));
    rst_n = 1'b0; #1;
    chk("mid_rst_cnt",   64'(bit_cnt),   64'(0));
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_data",  64'(out_data),  64'(0));
    step; rst_n = 1'b1;

    send_word(8'hA5, 1'b0);
    chk("a5_valid", 64'(out_valid), 64'(1));
    chk("a5_msb",   64'(out_data),  64'(8'hA5));
    chk("a5_lsb",   64'(lsb_data),  64'(8'hA5));
    step;
    chk("a5_once",  64'(out_valid), 64'(0));

    send_word(8'hC0, 1'b0);
    chk("c0_msb", 64'(out_data), 64'(8'hC0));
    chk("c0_lsb", 64'(lsb_data), 64'(8'h03));
    step;

    // back-pressure: hold 0x3C, stall the completing bit of 0xF0
    out_ready = 1'b0;
    send_word(8'h3C, 1'b0);
    chk("bp_valid", 64'(out_valid), 64'(1));
    chk("bp_data",  64'(out_data),  64'(8'h3C));
    for (int i = 0; i < FRAME-1; i++) send_bit(fbit(8'hF0, 1'b0, i));
    chk("bp_ready", 64'(in_ready), 64'(0));
    chk("bp_cnt",   64'(bit_cnt),  64'(FRAME-1));
    in_bit = fbit(8'hF0, 1'b0, FRAME-1); in_valid = 1'b1;
    step;
    chk("bp_stall_cnt", 64'(bit_cnt),  64'(FRAME-1));
    chk("bp_hold",      64'(out_data), 64'(8'h3C));
    out_ready = 1'b1;
    step; in_valid = 1'b0;
    chk("bp_swap_valid", 64'(out_valid), 64'(1));
    chk("bp_swap_data",  64'(out_data),  64'(8'hF0));
    chk("bp_swap_cnt",   64'(bit_cnt),   64'(0));
    step;
    chk("bp_drain", 64'(out_valid), 64'(0));

    stall_bad = 0; pulse_bad = 0;
    out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < FRAME; i++) begin
        in_bit = fbit(zb_words[w], ^zb_words[w], i); in_valid = 1'b1;
        if (!in_ready) stall_bad++;
        step;
        if (out_valid !== (i == FRAME-1)) pulse_bad++;
        if (i == FRAME-1) chk("zb_data", 64'(out_data), 64'(zb_words[w]));
      end
    end
    in_valid = 1'b0;
    chk("zb_stalls", 64'(stall_bad), 64'(0));
    chk("zb_pulses", 64'(pulse_bad), 64'(0));
    step;

    out_ready = 1'b0;
    send_word(8'h5A, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("clr_pre_cnt", 64'(bit_cnt), 64'(4));
    clr = 1'b1; in_bit = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_cnt",   64'(bit_cnt),   64'(0));
    chk("clr_valid", 64'(out_valid), 64'(0));
    chk("clr_data",  64'(out_data),  64'(8'h5A));
    send_word(8'h96, 1'b0);
    chk("clr_next_valid", 64'(out_valid), 64'(1));
    chk("clr_next_data",  64'(out_data),  64'(8'h96));
    step;

`ifdef SIPO_PARITY_EN
    send_word(8'h0F, 1'b0);
    chk("par_ok_perr", 64'(out_perr), 64'(0));
    step;
    send_word(8'h0F, 1'b1);
    chk("par_bad_perr", 64'(out_perr), 64'(1));
    chk("par_bad_data", 64'(out_data), 64'(8'h0F));
    clr = 1'b1; step; clr = 1'b0;
    chk("par_clr_perr", 64'(out_perr), 64'(0));
`else
    send_word(8'h0F, 1'b1);
    chk("nopar_perr", 64'(out_perr), 64'(0));
    chk("nopar_data", 64'(out_data), 64'(8'h0F));
`endif
    step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
